mem_wb_stage: RTL and testbench

Parametrised MEM→WB pipeline stage register with a valid/ready handshake, stall back-pressure, synchronous flush and an optional skid buffer. It sits between the data-memory stage and register-file writeback. It resolves the memory-to-register mux before the data is registered, so WB sees one write-data bus. It also exports a forwarding view of its output entry to the hazard/forwarding unit.

---
 rtl/mem_wb_pkg.sv | 19 +
 rtl/pipe_skid_buf.sv | 78 +++++++
 rtl/mem_wb_stage.sv | 93 +++++++++
 tb/tb_mem_wb_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared MEM/WB pipeline types: default widths, writeback entry layout and stage-state encoding.
package mem_wb_pkg;

  localparam int XLEN_DEF    = 64;
  localparam int RADDR_W_DEF = 5;

  typedef struct packed {
    logic                   reg_write;
    logic [RADDR_W_DEF-1:0] rd;
    logic [XLEN_DEF-1:0]    data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: output always comes from the main entry, the skid entry holds overflow.
// in_ready and out_valid are decoded from the state register only, so neither depends on out_ready.
module pipe_skid_buf
  import mem_wb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output stage_state_t dbg_state
);

  // Handshake: a transfer happens on a port exactly when valid & ready are both high at the rising edge.
  stage_state_t r_state, w_state_nxt;
  logic [W-1:0] r_main, r_skid;
  logic         w_acc, w_ret, w_main_load, w_main_from_skid, w_skid_load;

  assign in_ready  = (r_state != TWO);
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main;
  assign dbg_state = r_state;

  assign w_acc = in_valid & in_ready;
  assign w_ret = out_valid & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_acc) begin
          w_state_nxt = ONE;
          w_main_load = 1'b1;
        end
        ONE: begin
          if (w_acc && !w_ret) begin
            w_state_nxt = TWO;
            w_skid_load = 1'b1;
          end else if (!w_acc && w_ret) begin
            w_state_nxt = EMPTY;
          end else if (w_acc && w_ret) begin
            w_main_load = 1'b1;
          end
        end
        TWO: if (w_ret) begin
          w_state_nxt      = ONE;
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_main_load) r_main <= w_main_from_skid ? r_skid : in_data;
      if (w_skid_load) r_skid <= in_data;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB stage register: resolves the mem-to-reg mux, suppresses x0 writes, and exposes a forwarding view.
// SKID=1 uses a registered 2-entry skid buffer; SKID=0 a single entry with combinational in_ready.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter bit SKID    = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mem_to_reg,
  input  logic               in_reg_write,
  input  logic [XLEN-1:0]    in_read_data,
  input  logic [XLEN-1:0]    in_alu_result,
  input  logic [RADDR_W-1:0] in_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_reg_write,
  output logic [RADDR_W-1:0] out_rd,
  output logic [XLEN-1:0]    out_wb_data,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]    fwd_data,
  output stage_state_t       dbg_state
);

  localparam int PW = 1 + RADDR_W + XLEN;

  // Payload layout {reg_write_eff, rd, wb_data} matches wb_entry_t at default widths.
  logic [XLEN-1:0] w_wb_data;
  logic            w_rw_eff;
  logic [PW-1:0]   w_in_payload, w_out_payload;
  logic            w_in_ready, w_out_valid;

  assign w_wb_data    = in_mem_to_reg ? in_read_data : in_alu_result;
  assign w_rw_eff     = in_reg_write & (in_rd != '0);
  assign w_in_payload = {w_rw_eff, in_rd, w_wb_data};

  generate
    if (SKID) begin : g_skid
      pipe_skid_buf #(.W(PW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (w_in_ready),
        .in_data   (w_in_payload),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_payload),
        .dbg_state (dbg_state)
      );
    end else begin : g_single
      logic          r_valid;
      logic [PW-1:0] r_payload;
      logic          w_acc, w_ret;

      assign w_in_ready    = ~r_valid | out_ready;
      assign w_acc         = in_valid & w_in_ready;
      assign w_ret         = r_valid & out_ready;
      assign w_out_valid   = r_valid;
      assign w_out_payload = r_payload;
      assign dbg_state     = r_valid ? ONE : EMPTY;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid   <= 1'b0;
          r_payload <= '0;
        end else begin
          if (flush)      r_valid <= 1'b0;
          else if (w_acc) r_valid <= 1'b1;
          else if (w_ret) r_valid <= 1'b0;
          if (w_acc && !flush) r_payload <= w_in_payload;
        end
      end
    end
  endgenerate

  assign in_ready      = w_in_ready;
  assign out_valid     = w_out_valid;
  // Gate the stored write enable so a stale payload never looks like a write.
  assign out_reg_write = w_out_valid & w_out_payload[PW-1];
  assign out_rd        = w_out_payload[PW-2:XLEN];
  assign out_wb_data   = w_out_payload[XLEN-1:0];
  assign fwd_valid     = out_valid & out_reg_write;
  assign fwd_rd        = out_rd;
  assign fwd_data      = out_wb_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: SKID=1 instance for basic/back-pressure/flush/reset,
// SKID=0 instance for a random-ready stream against an expected queue.
module tb_mem_wb_stage;
  import mem_wb_pkg::*;

  localparam int XLEN = 64;
  localparam int RW   = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // SKID=1 instance signals
  logic            flush, in_valid, in_mem_to_reg, in_reg_write, out_ready;
  logic [XLEN-1:0] in_read_data, in_alu_result;
  logic [RW-1:0]   in_rd;
  logic            in_ready, out_valid, out_reg_write, fwd_valid;
  logic [RW-1:0]   out_rd, fwd_rd;
  logic [XLEN-1:0] out_wb_data, fwd_data;
  stage_state_t    dbg_state;

  // SKID=0 instance signals
  logic            b_flush, b_in_valid, b_in_mem_to_reg, b_in_reg_write, b_out_ready;
  logic [XLEN-1:0] b_in_read_data, b_in_alu_result;
  logic [RW-1:0]   b_in_rd;
  logic            b_in_ready, b_out_valid, b_out_reg_write, b_fwd_valid;
  logic [RW-1:0]   b_out_rd, b_fwd_rd;
  logic [XLEN-1:0] b_out_wb_data, b_fwd_data;
  stage_state_t    b_dbg_state;

  mem_wb_stage #(.XLEN(XLEN), .RADDR_W(RW), .SKID(1'b1)) u_dut_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
    .in_read_data(in_read_data), .in_alu_result(in_alu_result), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_reg_write(out_reg_write),
    .out_rd(out_rd), .out_wb_data(out_wb_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .dbg_state(dbg_state)
  );

  mem_wb_stage #(.XLEN(XLEN), .RADDR_W(RW), .SKID(1'b0)) u_dut_single (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_mem_to_reg(b_in_mem_to_reg), .in_reg_write(b_in_reg_write),
    .in_read_data(b_in_read_data), .in_alu_result(b_in_alu_result), .in_rd(b_in_rd),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_reg_write(b_out_reg_write),
    .out_rd(b_out_rd), .out_wb_data(b_out_wb_data),
    .fwd_valid(b_fwd_valid), .fwd_rd(b_fwd_rd), .fwd_data(b_fwd_data),
    .dbg_state(b_dbg_state)
  );

  // scoreboard
  int n_total = 0;
  int n_pass  = 0;
  logic [1+RW+XLEN-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m2r, input logic rw, input logic [RW-1:0] rd,
                       input logic [XLEN-1:0] rdata, input logic [XLEN-1:0] alu);
    in_valid      = v;
    in_mem_to_reg = m2r;
    in_reg_write  = rw;
    in_rd         = rd;
    in_read_data  = rdata;
    in_alu_result = alu;
    #1;
  endtask

  initial begin
    logic [XLEN-1:0] d, rdat;
    logic            m2r, rw_in;
    logic [RW-1:0]   rd_v;
    logic [1+RW+XLEN-1:0] obs_e, exp_e;
    int k, guard;

    flush = 0; out_ready = 0;
    in_valid = 0; in_mem_to_reg = 0; in_reg_write = 0; in_rd = '0;
    in_read_data = '0; in_alu_result = '0;
    b_flush = 0; b_out_ready = 0;
    b_in_valid = 0; b_in_mem_to_reg = 0; b_in_reg_write = 0; b_in_rd = '0;
    b_in_read_data = '0; b_in_alu_result = '0;

    // reset state
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_reg_write", {63'd0, out_reg_write}, 64'd0);
    chk("rst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    chk("rst_out_rd", {59'd0, out_rd}, 64'd0);
    chk("rst_out_wb_data", out_wb_data, 64'd0);
    chk("rst_fwd_data", fwd_data, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_b_in_ready", {63'd0, b_in_ready}, 64'd1);
    chk("rst_b_out_valid", {63'd0, b_out_valid}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1;
    tick();

    // basic: load data path, then ALU path
    out_ready = 1;
    drive(1, 1, 1, 5'd3, 64'hA5, 64'h11);
    tick();
    chk("basic_out_valid", {63'd0, out_valid}, 64'd1);
    chk("basic_wb_data", out_wb_data, 64'hA5);
    chk("basic_out_rd", {59'd0, out_rd}, 64'd3);
    chk("basic_fwd_valid", {63'd0, fwd_valid}, 64'd1);
    chk("basic_fwd_data", fwd_data, 64'hA5);
    chk("basic_fwd_rd", {59'd0, fwd_rd}, 64'd3);
    drive(1, 0, 1, 5'd4, 64'hA5, 64'h11);
    tick();
    chk("alu_out_valid", {63'd0, out_valid}, 64'd1);
    chk("alu_wb_data", out_wb_data, 64'h11);
    chk("alu_out_rd", {59'd0, out_rd}, 64'd4);
    // x0 suppression
    drive(1, 0, 1, 5'd0, 64'h0, 64'h22);
    tick();
    chk("x0_out_valid", {63'd0, out_valid}, 64'd1);
    chk("x0_wb_data", out_wb_data, 64'h22);
    chk("x0_out_reg_write", {63'd0, out_reg_write}, 64'd0);
    chk("x0_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    drive(0, 0, 0, 5'd0, 64'h0, 64'h0);
    tick();
    chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
    chk("drain_out_reg_write", {63'd0, out_reg_write}, 64'd0);

    // back-pressure: three entries with out_ready low
    out_ready = 0;
    drive(1, 0, 1, 5'd1, 64'h0, 64'h1);
    chk("bp_in_ready_0", {63'd0, in_ready}, 64'd1);
    tick();
    drive(1, 0, 1, 5'd2, 64'h0, 64'h2);
    chk("bp_in_ready_1", {63'd0, in_ready}, 64'd1);
    tick();
    drive(1, 0, 1, 5'd3, 64'h0, 64'h3);
    chk("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
    chk("bp_state_two", {62'd0, dbg_state}, {62'd0, TWO});
    tick();
    chk("bp_hold_data", out_wb_data, 64'h1);
    chk("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1;
    #1;
    chk("bp_in_ready_no_comb", {63'd0, in_ready}, 64'd0);
    tick();
    chk("bp_order_2", out_wb_data, 64'h2);
    chk("bp_order_2_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_in_ready_one", {63'd0, in_ready}, 64'd1);
    tick();
    chk("bp_order_3", out_wb_data, 64'h3);
    chk("bp_order_3_valid", {63'd0, out_valid}, 64'd1);
    drive(0, 0, 0, 5'd0, 64'h0, 64'h0);
    tick();
    chk("bp_empty", {63'd0, out_valid}, 64'd0);

    // flush with two held entries and a presented input
    out_ready = 0;
    drive(1, 0, 1, 5'd5, 64'h0, 64'h31);
    tick();
    drive(1, 0, 1, 5'd6, 64'h0, 64'h32);
    tick();
    drive(1, 0, 1, 5'd7, 64'h0, 64'h33);
    flush = 1;
    #1;
    chk("fl_in_ready_normal", {63'd0, in_ready}, 64'd0);
    tick();
    flush = 0;
    chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_out_reg_write", {63'd0, out_reg_write}, 64'd0);
    chk("fl_state", {62'd0, dbg_state}, {62'd0, EMPTY});
    drive(0, 0, 0, 5'd0, 64'h0, 64'h0);
    out_ready = 1;
    tick();
    chk("fl_stays_empty", {63'd0, out_valid}, 64'd0);
    // flush while an accept happens in the same cycle
    out_ready = 0;
    drive(1, 0, 1, 5'd8, 64'h0, 64'h41);
    tick();
    drive(1, 0, 1, 5'd9, 64'h0, 64'h42);
    flush = 1;
    #1;
    chk("fl2_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    flush = 0;
    chk("fl2_out_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1;
    drive(1, 0, 1, 5'd10, 64'h0, 64'h43);
    tick();
    chk("fl2_next_data", out_wb_data, 64'h43);
    chk("fl2_next_valid", {63'd0, out_valid}, 64'd1);
    drive(0, 0, 0, 5'd0, 64'h0, 64'h0);
    tick();
    chk("fl2_no_residual", {63'd0, out_valid}, 64'd0);

    // asynchronous reset while TWO
    out_ready = 0;
    drive(1, 0, 1, 5'd11, 64'h0, 64'h51);
    tick();
    drive(1, 0, 1, 5'd12, 64'h0, 64'h52);
    tick();
    chk("ar_state_two", {62'd0, dbg_state}, {62'd0, TWO});
    #2 rst_n = 0;
    #1;
    chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_wb_data", out_wb_data, 64'd0);
    chk("ar_out_rd", {59'd0, out_rd}, 64'd0);
    chk("ar_fwd_data", fwd_data, 64'd0);
    chk("ar_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    chk("ar_in_ready", {63'd0, in_ready}, 64'd1);
    drive(0, 0, 0, 5'd0, 64'h0, 64'h0);
    @(posedge clk);
    #3 rst_n = 1;
    out_ready = 1;
    drive(1, 1, 1, 5'd13, 64'h61, 64'h0);
    tick();
    chk("ar_first_after", out_wb_data, 64'h61);
    chk("ar_first_rd", {59'd0, out_rd}, 64'd13);
    drive(0, 0, 0, 5'd0, 64'h0, 64'h0);
    tick();
    chk("ar_empty_after", {63'd0, out_valid}, 64'd0);

    // SKID=0: full-rate stream with random out_ready
    for (k = 0; k < 48; k++) begin
      m2r   = k[0];
      rw_in = (k % 5) != 0;
      rd_v  = k[4:0];
      d     = 64'h100 + 64'(k);
      rdat  = 64'hC000 + 64'(k);
      b_in_valid      = 1;
      b_in_mem_to_reg = m2r;
      b_in_reg_write  = rw_in;
      b_in_rd         = rd_v;
      b_in_read_data  = rdat;
      b_in_alu_result = d;
      b_out_ready     = ($urandom_range(0, 3) != 0);
      #1;
      chk("s0_in_ready_rule", {63'd0, b_in_ready}, {63'd0, (~b_out_valid) | b_out_ready});
      if (b_out_valid && b_out_ready) begin
        exp_e = exp_q.pop_front();
        obs_e = {b_out_reg_write, b_out_rd, b_out_wb_data};
        n_total++;
        assert (obs_e === exp_e) n_pass++;
        else $error("FAIL s0_order: observed 0x%0h expected 0x%0h", obs_e, exp_e);
      end
      if (b_in_valid && b_in_ready)
        exp_q.push_back({rw_in & (rd_v != 5'd0), rd_v, m2r ? rdat : d});
      tick();
    end
    b_in_valid  = 0;
    b_out_ready = 1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      #1;
      if (b_out_valid) begin
        exp_e = exp_q.pop_front();
        obs_e = {b_out_reg_write, b_out_rd, b_out_wb_data};
        n_total++;
        assert (obs_e === exp_e) n_pass++;
        else $error("FAIL s0_drain: observed 0x%0h expected 0x%0h", obs_e, exp_e);
      end
      tick();
      guard++;
    end
    chk("s0_queue_empty", 64'(exp_q.size()), 64'd0);
    #1;
    chk("s0_out_valid_end", {63'd0, b_out_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
